// File: rtl/encode_tx.sv
// Packet encoder/serializer: latches a request, builds a 55-bit frame
// {type, addr, raw} in one cycle and shifts it out MSB first, pausing while tx_hold is high.
module encode_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_req,
    input  logic [2:0]  tx_type,
    input  logic [3:0]  tx_addr,
    input  logic [23:0] tx_payload,
    input  logic        tx_hold,
    output logic        tx_ack,
    output logic        tx_err,
    output logic        tx_busy,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        ser_sof,
    output logic        tx_done
);

    typedef enum logic [1:0] {IDLE, ENCODE, SEND, DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [3:0]  addr_q, addr_d;
    logic [23:0] payload_q, payload_d;
    logic [54:0] frame_q, frame_d;
    logic [5:0]  count_q, count_d;
    logic        err_q, err_d;

    logic [47:0] raw;
    logic [3:0]  cks;
    logic [5:0]  bit_idx;

    function automatic logic [5:0] enc_3of6(input logic [2:0] g);
        logic [5:0] cw;
        case (g)
            3'd0:    cw = 6'b000111;
            3'd1:    cw = 6'b001011;
            3'd2:    cw = 6'b001101;
            3'd3:    cw = 6'b001110;
            3'd4:    cw = 6'b010011;
            3'd5:    cw = 6'b010101;
            3'd6:    cw = 6'b010110;
            default: cw = 6'b011001;
        endcase
        return cw;
    endfunction

    // Raw data field built from the latched request; control packets carry none.
    always_comb begin
        cks = payload_q[23:20] ^ payload_q[19:16] ^ payload_q[15:12] ^
              payload_q[11:8]  ^ payload_q[7:4]   ^ payload_q[3:0];
        raw = '0;
        case (type_q)
            3'b011: raw = {payload_q, cks, 20'h0};
            3'b100: begin
                for (int i = 0; i < 8; i++) begin
                    raw[6*i +: 6] = enc_3of6(payload_q[3*i +: 3]);
                end
            end
            default: raw = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        payload_d = payload_q;
        frame_d   = frame_q;
        count_d   = count_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_req) begin
                    if (tx_type <= 3'd4) begin
                        type_d    = tx_type;
                        addr_d    = tx_addr;
                        payload_d = tx_payload;
                        state_d   = ENCODE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ENCODE: begin
                frame_d = {type_q, addr_q, raw};
                count_d = '0;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_hold) begin
                    if (count_q == 6'd54) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            type_q    <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            frame_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            payload_q <= payload_d;
            frame_q   <= frame_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // Serial outputs follow the state directly; tx_hold gates the bit in the same cycle.
    assign bit_idx   = 6'd54 - count_q;
    assign tx_ack    = (state_q == ENCODE);
    assign tx_err    = err_q;
    assign tx_busy   = (state_q != IDLE);
    assign ser_valid = (state_q == SEND) && !tx_hold;
    assign ser_out   = ser_valid & frame_q[bit_idx];
    assign ser_sof   = ser_valid && (count_q == 6'd0);
    assign tx_done   = (state_q == DONE);

endmodule

// File: tb/tb_encode_tx.sv
// Bench for encode_tx: table of packets with expected frames; a bit queue
// scoreboards the serial stream while cycle stamps of ack/err/done are checked.
module tb_encode_tx;

    logic        clk = 1'b0;
    logic        rst, tx_req, tx_hold;
    logic [2:0]  tx_type;
    logic [3:0]  tx_addr;
    logic [23:0] tx_payload;
    logic        tx_ack, tx_err, tx_busy, ser_out, ser_valid, ser_sof, tx_done;

    encode_tx dut (
        .clk(clk), .rst(rst), .tx_req(tx_req), .tx_type(tx_type), .tx_addr(tx_addr),
        .tx_payload(tx_payload), .tx_hold(tx_hold), .tx_ack(tx_ack), .tx_err(tx_err),
        .tx_busy(tx_busy), .ser_out(ser_out), .ser_valid(ser_valid), .ser_sof(ser_sof),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [3:0]  a;
        logic [23:0] p;
        logic        exp_err;
        logic [54:0] frame;
    } vec_t;

    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    bit   exp_q[$];
    logic s_ack, s_err, s_done, s_busy, s_valid, s_out, s_sof;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [2:0] t, input logic [3:0] a,
                                 input logic [23:0] p, input logic hold, input logic r);
        tx_req     = req;
        tx_type    = t;
        tx_addr    = a;
        tx_payload = p;
        tx_hold    = hold;
        rst        = r;
    endtask

    task automatic pushFrame(input logic [54:0] f);
        for (int i = 54; i >= 0; i--) exp_q.push_back(f[i]);
    endtask

    // One clock cycle: sample mid-cycle, scoreboard the serial lines, advance to just after the edge.
    task automatic step();
        bit b;
        #2;
        s_ack = tx_ack; s_err = tx_err; s_done = tx_done; s_busy = tx_busy;
        s_valid = ser_valid; s_out = ser_out; s_sof = ser_sof;
        if (s_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected ser_valid", 1, 0);
            end else begin
                checkOutput("ser_sof", s_sof, (exp_q.size() == 55));
                b = exp_q.pop_front();
                checkOutput("ser_out bit", s_out, b);
            end
        end else begin
            checkOutput("serial lines idle", {s_out, s_sof}, 2'b00);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runFrame(input vec_t v, input int hold_start, input int hold_len,
                            input int exp_done, input string tag);
        int  ack_c, err_c, done_c;
        bit  busy_seen;
        ack_c = -1; err_c = -1; done_c = -1; busy_seen = 0;
        if (!v.exp_err) pushFrame(v.frame);
        for (int c = 0; c < 120; c++) begin
            applyStimulus(c == 0, v.t, v.a, v.p, (c >= hold_start) && (c < hold_start + hold_len), 1'b0);
            step();
            if (s_ack && ack_c < 0) ack_c = c;
            if (s_err && err_c < 0) err_c = c;
            if (s_done && done_c < 0) done_c = c;
            if (s_busy) busy_seen = 1;
            if (done_c >= 0 || (v.exp_err && c >= 4)) break;
        end
        applyStimulus(1'b0, 3'd0, 4'd0, 24'd0, 1'b0, 1'b0);
        if (v.exp_err) begin
            checkOutput($sformatf("%s err cycle", tag), err_c, 1);
            checkOutput($sformatf("%s no ack", tag), ack_c, -1);
            checkOutput($sformatf("%s busy never", tag), busy_seen, 0);
        end else begin
            checkOutput($sformatf("%s ack cycle", tag), ack_c, 1);
            checkOutput($sformatf("%s done cycle", tag), done_c, exp_done);
            checkOutput($sformatf("%s no err", tag), err_c, -1);
            checkOutput($sformatf("%s all bits sent", tag), exp_q.size(), 0);
        end
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acks, dones;
        vec_t v;

        vecs[0] = '{3'b011, 4'hA, 24'h123456, 1'b0, {3'b011, 4'hA, 24'h123456, 4'h7, 20'h0}};
        vecs[1] = '{3'b100, 4'h1, 24'h000000, 1'b0, {3'b100, 4'h1, {8{6'b000111}}}};
        vecs[2] = '{3'b100, 4'h2, 24'hFFFFFF, 1'b0, {3'b100, 4'h2, {8{6'b011001}}}};
        vecs[3] = '{3'b000, 4'h3, 24'hABCDEF, 1'b0, {3'b000, 4'h3, 48'h0}};
        vecs[4] = '{3'b110, 4'h4, 24'h111111, 1'b1, 55'h0};
        vecs[5] = '{3'b001, 4'hF, 24'h55AA55, 1'b0, {3'b001, 4'hF, 48'h0}};
        vecs[6] = '{3'b010, 4'h0, 24'hFFFFFF, 1'b0, {3'b010, 4'h0, 48'h0}};
        vecs[7] = '{3'b011, 4'h5, 24'h0000A5, 1'b0, {3'b011, 4'h5, 24'h0000A5, 4'hF, 20'h0}};
        vecs[8] = '{3'b100, 4'h6, 24'h053977, 1'b0,
                    {3'b100, 4'h6, 6'b000111, 6'b001011, 6'b001101, 6'b001110,
                     6'b010011, 6'b010101, 6'b010110, 6'b011001}};
        vecs[9] = '{3'b111, 4'h7, 24'h000001, 1'b1, 55'h0};

        applyStimulus(1'b0, 3'd0, 4'd0, 24'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 3'd0, 4'd0, 24'd0, 1'b0, 1'b0);
        step();
        checkOutput("reset outputs", {s_ack, s_err, s_busy, s_out, s_valid, s_sof, s_done}, 7'b0);

        for (int i = 0; i < 10; i++) begin
            runFrame(vecs[i], 1000, 0, 57, $sformatf("vec%0d", i));
        end

        runFrame(vecs[0], 10, 5, 62, "hold mid-frame");
        runFrame(vecs[8], 2, 3, 60, "hold first bit");
        runFrame(vecs[3], 0, 2, 57, "hold in idle/encode");
        v = vecs[4];
        v.t = 3'b101;
        runFrame(v, 1000, 0, 0, "illegal 101");

        // Abort a frame with reset at cycle 30; a second request at cycle 20 must be ignored.
        acks = 0; dones = 0;
        pushFrame(vecs[8].frame);
        for (int c = 0; c < 41; c++) begin
            if (c == 20) applyStimulus(1'b1, 3'b001, 4'h9, 24'h0, 1'b0, 1'b0);
            else         applyStimulus(c == 0, vecs[8].t, vecs[8].a, vecs[8].p, 1'b0, c == 30);
            step();
            if (s_ack) acks++;
            if (s_done) dones++;
            if (c == 30) exp_q.delete();
            if (c == 31) checkOutput("outputs after mid-frame reset",
                                     {s_ack, s_err, s_busy, s_out, s_valid, s_sof, s_done}, 7'b0);
        end
        checkOutput("reset abort ack count", acks, 1);
        checkOutput("reset abort no done", dones, 0);

        runFrame(vecs[5], 1000, 0, 57, "after abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encode_tx.md
ENCODE_TX -- requirements
Module: encode_tx

Interface
- No parameters; frame width fixed at 55 bits (3 type + 4 addr + 48 data).
- REQ-001: clk  input  1  system clock; all state updates on rising edge.
- REQ-002: rst  input  1  synchronous, active-high reset.
- REQ-003: tx_req  input  1  node requests transmission of one packet.
- REQ-004: tx_type  input  3  packet type: 000 token, 001 ack, 010 nack, 011 checksum data, 100 3-of-6 data; 101-111 illegal.
- REQ-005: tx_addr  input  4  destination node address.
- REQ-006: tx_payload  input  24  node data; used only for types 011/100.
- REQ-007: tx_hold  input  1  link not available; freezes serialization.
- REQ-008: tx_ack  output  1  one-cycle pulse: request accepted.
- REQ-009: tx_err  output  1  one-cycle pulse: request rejected, illegal type.
- REQ-010: tx_busy  output  1  high in every state except IDLE.
- REQ-011: ser_out  output  1  serial frame bit, MSB (bit 54) first.
- REQ-012: ser_valid  output  1  ser_out carries a frame bit this cycle.
- REQ-013: ser_sof  output  1  high with frame bit 54 only.
- REQ-014: tx_done  output  1  one-cycle pulse after last bit sent.

Function
- REQ-015: Frame layout SHALL be {type[2:0], addr[3:0], raw[47:0]} = bits [54:52], [51:48], [47:0].
- REQ-016: Types 000/001/010 SHALL use raw = 48'h0; payload ignored.
- REQ-017: Type 011 SHALL use raw = {payload[23:0], cks[3:0], 20'h0}; cks = XOR of the six payload nibbles.
- REQ-018: Type 100 SHALL split payload into 8 groups, payload[23:21] to raw[47:42] ... payload[2:0] to raw[5:0], each 3-bit group encoded as 6-bit 3-of-6 codeword.
- REQ-019: 3-of-6 table: 0=000111, 1=001011, 2=001101, 3=001110, 4=010011, 5=010101, 6=010110, 7=011001.
- REQ-020: States: IDLE, ENCODE, SEND, DONE.
- REQ-021: IDLE: tx_req=1 with legal type SHALL latch type/addr/payload and go to ENCODE; tx_ack=1 during the ENCODE cycle.
- REQ-022: IDLE: tx_req=1 with illegal type SHALL pulse tx_err next cycle, no ack, remain IDLE.
- REQ-023: ENCODE: the 55-bit frame register SHALL load in exactly one cycle; 6-bit bit counter cleared; next state SEND.
- REQ-024: SEND with tx_hold=0: drive frame bit (54 - count), ser_valid=1, count+1. With tx_hold=1: ser_valid=0, count and frame frozen.
- REQ-025: After the bit with count=54 is driven, next state SHALL be DONE; DONE pulses tx_done for one cycle, then IDLE.
- REQ-026: Latency without hold: req sampled cycle 0, ack cycle 1, bit 54 cycle 2, bit 0 cycle 56, tx_done cycle 57; new req accepted when sampled in cycle 58.
- REQ-027: tx_req outside IDLE SHALL be ignored (no ack, no err, latched values unchanged).
- REQ-028: ser_out SHALL be 0 whenever ser_valid=0.
- REQ-029: tx_hold in IDLE/ENCODE/DONE SHALL have no effect; hold on the first SEND cycle delays ser_sof with bit 54.

Reset
- REQ-030: rst=1 SHALL force IDLE, clear counter and frame; tx_ack, tx_err, tx_busy, ser_out, ser_valid, ser_sof, tx_done = 0 the following cycle.
- REQ-031: rst mid-frame SHALL abort without tx_done; no further ser_valid until a new accepted request.

Verification
- REQ-032: type=011, addr=A, payload=123456 -> 55 bits = 011,1010,123456,0111,20 zeros; ack cycle 1, done cycle 57.
- REQ-033: type=100, payload=000000 then FFFFFF -> raw = 000111 x8, then 011001 x8; each group has exactly three ones.
- REQ-034: type=000, addr=3, payload=ABCDEF -> frame = 000,0011,48 zeros.
- REQ-035: type=110 -> tx_err pulse cycle 1, tx_busy stays 0, no ser_valid.
- REQ-036: tx_hold=1 for cycles 10-14 during SEND -> ser_valid low there, no bit skipped or repeated, tx_done at cycle 62.
- REQ-037: rst at cycle 30 of a frame plus a second tx_req while busy -> outputs 0 next cycle, second req never acked.
